spi_slave_gen: RTL
==================

// Module: spi_slave_gen
// PURPOSE
//  Parametrised SPI slave front-end for the dual-port RAM subsystem; successor to the fixed 8-bit slave.
//  Deserialises a 2-bit command + DATA_W payload from MOSI; presents it to the RAM on rx_data/rx_valid.
//  Read-data frames wait for RAM tx_data/tx_valid and serialise DATA_W bits on MISO.
//  Adds explicit command decode, tx wait timeout, abort handling; MOSI/SS_n are sampled on clk.
// PARAMETERS
//  DATA_W      8    payload width (addr/data bits); rx word = DATA_W+2
//  TX_TIMEOUT  255  max clk cycles waiting for tx_valid in a read-data frame (>=1)
// PORTS
//  clk       in   1         single clock; all MOSI/SS_n sampling on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  SS_n      in   1         slave select, active low; high = frame end/abort
//  MOSI      in   1         serial in, MSB first
//  MISO      out  1         serial out, MSB first; 0 when not transmitting
//  rx_data   out  DATA_W+2  {cmd[1:0], payload}; cmd 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//  rx_valid  out  1         one-cycle pulse: rx_data complete
//  tx_data   in   DATA_W    read data from RAM
//  tx_valid  in   1         tx_data valid; sampled only in TX_WAIT
//  busy      out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE, MISO=0, rx_data=0, rx_valid=0, busy=0, counters 0.
//  States: IDLE, RX, TX_WAIT, TX, DONE.
//  IDLE: edge with SS_n=0 samples MOSI as bit 0 (rx_data MSB), -> RX, bit count=1.
//  RX: one bit per edge, shift left into rx_data. Edge sampling bit DATA_W+1 (last):
//   rx_valid=1 for exactly that following cycle; rx_data final value held until next frame's first bit.
//   cmd==11 -> TX_WAIT, else -> DONE.
//  TX_WAIT: edge with tx_valid=1 loads tx_data into shift reg, MISO<=tx_data[DATA_W-1], -> TX.
//   Wait counter increments per cycle; reaching TX_TIMEOUT -> DONE, MISO stays 0.
//  TX: each edge shifts next bit to MISO; after DATA_W bits driven (DATA_W cycles incl. load), -> DONE, MISO<=0.
//  DONE: idle-in-frame, MISO=0, extra MOSI bits ignored; SS_n=1 -> IDLE.
//  SS_n=1 in any state: next edge -> IDLE, MISO<=0, counters cleared, no rx_valid; rx_data not updated.
//  SS_n rise on the same edge as last RX bit: frame aborted, no rx_valid.
//  tx_valid outside TX_WAIT ignored; tx_valid and timeout on same edge: tx_valid wins.
//  Counters sized $clog2(DATA_W+3) and $clog2(TX_TIMEOUT+1); no wrap within a frame.
//  Reset mid-frame: immediate return to reset values, regardless of SS_n.
// CONFIGURATION
//  SPI_FRAME_ERR_EN defined: extra output frame_err (1 bit, reset 0), one-cycle pulse when
//   SS_n rises in RX/TX_WAIT/TX, or on TX_WAIT timeout.
//  Not defined: port absent, no error logic; all other behaviour identical.
// STRUCTURE
//  Package spi_slave_pkg: state encoding localparams (sequential), command codes
//   CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
//  Sub-module spi_shift_reg (parametrised width, load/shift-in/shift-out) instanced twice: RX and TX.
//  FSM, counters, timeout in top level.
// TESTING
//  Wr-addr: SS_n=0, MOSI 00_10100101 -> rx_data=10'h0A5, rx_valid high 1 cycle after 10th edge, MISO=0.
//  Rd-data: MOSI 11_xxxxxxxx, tx_valid+tx_data=8'h3C 3 cycles later -> MISO 0,0,1,1,1,1,0,0 then 0.
//  Abort: SS_n=1 after 5 bits -> no rx_valid, IDLE next edge; frame_err pulse if SPI_FRAME_ERR_EN.
//  Timeout: rd-data frame, TX_TIMEOUT=4, no tx_valid -> DONE after 4 cycles, MISO stays 0.
//  Reset: rst_n low mid-TX -> MISO, rx_valid, busy 0 asynchronously; clean frame after release.
//  DATA_W=16: wr-data 01_16'hBEEF -> rx_data=18'h1BEEF after 18 edges; rd-data returns 16'h1234 MSB first.

Source files
------------

// File: rtl/spi_slave_gen_pkg.sv
// Shared definitions for the SPI slave front-end: FSM state encoding,
// command codes and a small state-classification helper.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_TX      = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // States in which a frame is still being transferred; leaving one of
  // them through SS_n is an incomplete frame.
  function automatic logic frame_open(input state_e s);
    return (s == ST_RX) || (s == ST_TX_WAIT) || (s == ST_TX);
  endfunction

endpackage

// File: rtl/spi_slave_gen_if.sv
// Bus bundle between the SPI slave front-end and its environment:
// serial pins, RAM-side receive word and transmit data handshake.
// With SPI_FRAME_ERR_EN defined the bundle also carries frame_err.
interface spi_slave_gen_if #(parameter int DATA_W = 8);

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              busy;
`ifdef SPI_FRAME_ERR_EN
  logic              frame_err;

  modport slave  (input SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid, busy, frame_err);
  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input MISO, rx_data, rx_valid, busy, frame_err);
`else
  modport slave  (input SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid, busy);
  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input MISO, rx_data, rx_valid, busy);
`endif

endinterface

// File: rtl/spi_slave_gen_shift_reg.sv
// Generic MSB-first shift register: parallel load has priority over a
// left shift; sout is the current MSB (serial output).
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         shift_in,
  output logic [W-1:0] q,
  output logic         sout
);

  logic [W-1:0] q_q, q_d;

  // Next value: load wins over shift, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = (q_q << 1) | W'(shift_in);
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q    = q_q;
  assign sout = q_q[W-1];

endmodule

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave front-end. MOSI/SS_n are sampled on clk; a frame is
// a 2-bit command plus DATA_W payload bits, MSB first. Read-data frames wait
// up to TX_TIMEOUT cycles for tx_valid and then serialise tx_data on MISO.
// Optional macro SPI_FRAME_ERR_EN adds the frame_err pulse output.
module spi_slave_gen
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  spi_slave_gen_if.slave  bus
);

  localparam int CNT_W  = $clog2(DATA_W + 3);
  localparam int WAIT_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_RX_BIT = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_TX_BIT = CNT_W'(DATA_W);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(TX_TIMEOUT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
  logic                rx_valid_q, rx_valid_d;
`ifdef SPI_FRAME_ERR_EN
  logic                frame_err_q, frame_err_d;
`endif

  logic                rx_load, rx_shift, rx_msb_unused;
  logic [DATA_W+1:0]   rx_q, rx_first;
  logic [1:0]          cmd_in;
  logic                tx_load, tx_shift, miso_w;
  logic [DATA_W-1:0]   tx_load_val, tx_par_unused;

  // First bit of a frame replaces the previous word entirely.
  assign rx_first = {{(DATA_W+1){1'b0}}, bus.MOSI};
  // Command bits as they will stand once the current MOSI bit is shifted in.
  assign cmd_in   = rx_q[DATA_W:DATA_W-1];

  // Frame FSM: next state, counters and shift-register controls.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wait_inc    = wait_cnt_q + 1'b1;
    rx_valid_d  = 1'b0;
    rx_load     = 1'b0;
    rx_shift    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    tx_load_val = bus.tx_data;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif
    if (bus.SS_n) begin
      // Deselect ends or aborts the frame; the TX register is cleared so
      // MISO drops to 0 on the same edge.
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      wait_cnt_d  = '0;
      tx_load     = 1'b1;
      tx_load_val = '0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_d = frame_open(state_q);
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          rx_load   = 1'b1;
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_RX;
        end
        ST_RX: begin
          rx_shift = 1'b1;
          if (bit_cnt_q == LAST_RX_BIT) begin
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = (cmd_in == CMD_RD_DATA) ? ST_TX_WAIT : ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_TX_WAIT: begin
          if (bus.tx_valid) begin
            tx_load    = 1'b1;
            bit_cnt_d  = CNT_W'(1);
            wait_cnt_d = '0;
            state_d    = ST_TX;
          end else if (wait_inc == WAIT_MAX) begin
            wait_cnt_d = '0;
            state_d    = ST_DONE;
`ifdef SPI_FRAME_ERR_EN
            frame_err_d = 1'b1;
`endif
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
        ST_TX: begin
          // Shifting zeros in means the register is empty (MISO=0) exactly
          // when the last data bit has been held for one cycle.
          tx_shift = 1'b1;
          if (bit_cnt_q == LAST_TX_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      rx_valid_q  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rx_valid_q  <= rx_valid_d;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  spi_shift_reg #(.W(DATA_W + 2)) u_rx_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rx_load),
    .load_val (rx_first),
    .shift    (rx_shift),
    .shift_in (bus.MOSI),
    .q        (rx_q),
    .sout     (rx_msb_unused)
  );

  spi_shift_reg #(.W(DATA_W)) u_tx_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_val (tx_load_val),
    .shift    (tx_shift),
    .shift_in (1'b0),
    .q        (tx_par_unused),
    .sout     (miso_w)
  );

  assign bus.MISO     = miso_w;
  assign bus.rx_data  = rx_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q != ST_IDLE);
`ifdef SPI_FRAME_ERR_EN
  assign bus.frame_err = frame_err_q;
`endif

endmodule
